// File: rtl/stream_capture.sv
// rtl/stream_capture.sv - AXI-stream single-packet capture buffer with registered readout
module stream_capture #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  arm,
  input  logic [31:0]           samples,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  output logic                  s_tready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  err_short,
  output logic                  err_trunc
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic                    arm_q;
  logic [ADDR_WIDTH:0]     limit_q, limit_d;
  logic [ADDR_WIDTH:0]     count_q, count_d;
  logic                    err_short_q, err_short_d;
  logic                    err_trunc_q, err_trunc_d;
  logic [DATA_WIDTH-1:0]   rd_data_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    arm_edge;
  logic                    hs;
  logic [ADDR_WIDTH:0]     count_inc;
  logic [ADDR_WIDTH:0]     limit_at_arm;

  assign arm_edge  = arm & ~arm_q;
  assign s_tready  = (state_q == S_CAPTURE);
  assign hs        = s_tvalid & s_tready;
  assign count_inc = count_q + ONE_C;

  assign busy      = (state_q == S_CAPTURE);
  assign done      = (state_q == S_DONE);
  assign count     = count_q;
  assign err_short = err_short_q;
  assign err_trunc = err_trunc_q;
  assign rd_data   = rd_data_q;

  // Zero or oversize requests fall back to a full-buffer capture
  always_comb begin
    limit_at_arm = samples[ADDR_WIDTH:0];
    if (samples == 32'd0 || samples > 32'(DEPTH)) begin
      limit_at_arm = DEPTH_C;
    end
  end

  // Next-state logic: arm edges start a capture, handshakes advance and close it
  always_comb begin
    state_d     = state_q;
    limit_d     = limit_q;
    count_d     = count_q;
    err_short_d = err_short_q;
    err_trunc_d = err_trunc_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm_edge) begin
          state_d     = S_CAPTURE;
          limit_d     = limit_at_arm;
          count_d     = '0;
          err_short_d = 1'b0;
          err_trunc_d = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (hs) begin
          count_d = count_inc;
          if (s_tlast) begin
            state_d     = S_DONE;
            err_short_d = (count_inc < limit_q);
          end else if (count_inc == limit_q) begin
            state_d     = S_DONE;
            err_trunc_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers and the registered read port
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      arm_q       <= 1'b0;
      limit_q     <= '0;
      count_q     <= '0;
      err_short_q <= 1'b0;
      err_trunc_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      arm_q       <= arm;
      limit_q     <= limit_d;
      count_q     <= count_d;
      err_short_q <= err_short_d;
      err_trunc_q <= err_trunc_d;
      rd_data_q   <= mem[rd_addr];
    end
  end

  // Buffer write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (hs) begin
      mem[count_q[ADDR_WIDTH-1:0]] <= s_tdata;
    end
  end

endmodule

// File: tb/tb_stream_capture.sv
// tb/tb_stream_capture.sv - randomized model-checked bench for stream_capture
`timescale 1ns/1ps
module tb_stream_capture;

  logic        clk = 1'b0;
  logic        resetn;
  logic        arm;
  logic [31:0] samples;
  logic [15:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        busy;
  logic        done;
  logic [4:0]  count;
  logic        err_short;
  logic        err_trunc;

  stream_capture #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) dut (
    .clk(clk), .resetn(resetn), .arm(arm), .samples(samples),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .count(count),
    .err_short(err_short), .err_trunc(err_trunc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Packet-level reference: is a capture open, how many beats it holds, how it ended
  bit          m_active, m_done, m_short, m_trunc, m_acc, m_arm_prev, m_rd_known;
  int          m_n, m_limit;
  logic [15:0] m_mem [16];
  bit          m_wr  [16];
  logic [15:0] m_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_done = 0; m_short = 0; m_trunc = 0; m_acc = 0;
    m_arm_prev = 0; m_n = 0; m_limit = 0; m_rd = 16'h0; m_rd_known = 1;
  endtask

  // What happens at one rising edge, given the inputs held across it
  task automatic model_edge();
    m_acc = 0;
    m_rd_known = m_wr[rd_addr];
    m_rd = m_mem[rd_addr];
    if (m_active) begin
      if (s_tvalid) begin
        m_acc = 1;
        m_mem[m_n] = s_tdata;
        m_wr[m_n] = 1;
        m_n++;
        if (s_tlast) begin
          m_active = 0; m_done = 1; m_short = (m_n < m_limit);
        end else if (m_n == m_limit) begin
          m_active = 0; m_done = 1; m_trunc = 1;
        end
      end
    end else if (arm && !m_arm_prev) begin
      m_active = 1; m_done = 0; m_short = 0; m_trunc = 0; m_n = 0;
      m_limit = (samples == 0 || samples > 16) ? 16 : int'(samples);
    end
    m_arm_prev = arm;
  endtask

  task automatic tick();
    @(posedge clk);
    if (resetn) model_edge();
    #1;
  endtask

  // Compare every output to the model on each falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("s_tready", 32'(s_tready), 32'(m_active));
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(m_done));
      chk("count", 32'(count), 32'(m_n));
      chk("err_short", 32'(err_short), 32'(m_short));
      chk("err_trunc", 32'(err_trunc), 32'(m_trunc));
      if (m_rd_known) chk("rd_data", 32'(rd_data), 32'(m_rd));
    end
  end

  task automatic arm_start(input logic [31:0] n);
    arm = 1'b0;
    tick();
    samples = n;
    arm = 1'b1;
    tick();
  endtask

  // vmode: 0 always valid, 1 alternate, 2 random; poke re-pulses arm mid-packet
  task automatic send(input int len, input logic [15:0] base, input int vmode, input bit poke);
    int i = 0;
    int cyc = 0;
    int stall = 0;
    while (i < len && stall < 3 && cyc < 200) begin
      s_tdata  = base + 16'(i);
      s_tlast  = (i == len - 1);
      s_tvalid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      rd_addr  = 4'($urandom_range(0, 15));
      if (poke) arm = (cyc == 3) ? 1'b0 : 1'b1;
      tick();
      if (m_acc) i++;
      if (!m_active) stall++;
      cyc++;
    end
    if (cyc >= 200) chk("send_timeout", 32'(cyc), 32'(0));
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic read_lit(input logic [3:0] a, input logic [15:0] exp);
    rd_addr = a;
    tick();
    chk("readout", 32'(rd_data), 32'(exp));
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin m_wr[k] = 0; m_mem[k] = 16'h0; end
    model_reset();
    resetn = 1'b0; arm = 1'b0; samples = 0; s_tdata = 0; s_tvalid = 0; s_tlast = 0; rd_addr = 0;
    repeat (2) tick();
    #2 resetn = 1'b1;
    chk_en = 1'b1;
    tick();
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_ready", 32'(s_tready), 32'(0));

    // exact-length packet
    arm_start(8);
    send(8, 16'h0000, 0, 0);
    tick();
    chk("t1_count", 32'(count), 32'(8));
    chk("t1_done", 32'(done), 32'(1));
    chk("t1_err", 32'({err_short, err_trunc}), 32'(0));
    for (int a = 0; a < 8; a++) read_lit(4'(a), 16'(a));

    // early tlast
    arm_start(8);
    send(5, 16'h0200, 0, 0);
    tick();
    chk("t2_count", 32'(count), 32'(5));
    chk("t2_short", 32'(err_short), 32'(1));
    chk("t2_trunc", 32'(err_trunc), 32'(0));
    chk("t2_ready", 32'(s_tready), 32'(0));

    // truncated packet, leftover beats stay pending
    arm_start(4);
    send(6, 16'h0300, 0, 0);
    chk("t3_count", 32'(count), 32'(4));
    chk("t3_trunc", 32'(err_trunc), 32'(1));
    for (int a = 0; a < 4; a++) read_lit(4'(a), 16'h0300 + 16'(a));

    // samples=0 means full buffer
    arm_start(0);
    send(20, 16'h0400, 0, 0);
    chk("t4_count", 32'(count), 32'(16));
    chk("t4_trunc", 32'(err_trunc), 32'(1));
    read_lit(4'd15, 16'h040F);

    // oversize request also clamps
    arm_start(20);
    send(20, 16'h0500, 0, 0);
    chk("t4b_count", 32'(count), 32'(16));

    // gapped valid and a mid-capture arm pulse, then re-arm from DONE
    arm_start(10);
    send(10, 16'h0600, 1, 1);
    chk("t5_count", 32'(count), 32'(10));
    chk("t5_done", 32'(done), 32'(1));
    arm_start(3);
    chk("t5_rearm_done", 32'(done), 32'(0));
    chk("t5_rearm_count", 32'(count), 32'(0));
    chk("t5_rearm_busy", 32'(busy), 32'(1));
    send(3, 16'h0700, 0, 0);
    tick();
    chk("t5_count2", 32'(count), 32'(3));

    // asynchronous reset mid-capture
    arm_start(12);
    for (int b = 0; b < 4; b++) begin
      s_tvalid = 1'b1; s_tdata = 16'h0800 + 16'(b); s_tlast = 1'b0;
      tick();
    end
    #2 resetn = 1'b0; arm = 1'b0; s_tvalid = 1'b0;
    model_reset();
    #1;
    chk("t6_busy", 32'(busy), 32'(0));
    chk("t6_count", 32'(count), 32'(0));
    chk("t6_ready", 32'(s_tready), 32'(0));
    chk("t6_rd", 32'(rd_data), 32'(0));
    @(posedge clk);
    #3 resetn = 1'b1;
    arm_start(6);
    send(6, 16'h0900, 0, 0);
    tick();
    chk("t6_count2", 32'(count), 32'(6));
    chk("t6_done2", 32'(done), 32'(1));

    // randomized packets checked by the model
    for (int p = 0; p < 40; p++) begin
      arm_start(32'($urandom_range(0, 20)));
      send($urandom_range(1, 20), 16'($urandom), 2, 0);
      repeat ($urandom_range(1, 4)) begin
        rd_addr = 4'($urandom_range(0, 15));
        tick();
      end
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
